mem_wb_data_stage: RTL and testbench

Memory-access stage of the ARM pipeline. It consumes the control bits held in the EX/MEM pipeline register (load, RF enable, size, read/write, memory enable) together with the EX-stage result and destination register. It performs byte or word access into a 256-byte big-endian data RAM and registers the write-back bundle (data, Rd, RF enable) for the register file. It replaces the bare MEM/WB control register with a full memory-plus-write-back stage.

---
 rtl/mem_wb_data_stage_pkg.sv | 22 ++
 rtl/mem_wb_data_stage_if.sv | 36 +++
 rtl/mem_wb_data_stage_data_ram_core.sv | 53 +++++
 rtl/mem_wb_data_stage.sv | 72 +++++++
 tb/tb_mem_wb_data_stage.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_data_stage_pkg.sv
// Shared ARM pipeline constants and the write-back bundle type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package arm_pipe_pkg;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;
    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;

    localparam int DATA_W   = 32;
    localparam int RF_IDX_W = 4;

    // Registered write-back bundle handed to the register file.
    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [RF_IDX_W-1:0] rd;
        logic                rf_enable;
        logic                align_err;
    } wb_t;

endpackage

// File: rtl/mem_wb_data_stage_if.sv
// EX/MEM control+data inputs and registered WB outputs of the memory stage.
// Latency: n/a (wiring only).
// Backpressure: none; one operation per cycle, no stall path.
interface mem_wb_data_stage_if #(
    parameter int ADDR_W = 8
);
    logic              in_MEM_load_instr;
    logic              in_MEM_RF_enable;
    logic              in_MEM_Size_enable;
    logic              in_MEM_RW_enable;
    logic              in_MEM_Enable_signal;
    logic [ADDR_W-1:0] in_address;
    logic [31:0]       in_alu_result;
    logic [31:0]       in_store_data;
    logic [3:0]        in_rd;
    logic [31:0]       WB_data;
    logic [3:0]        WB_rd;
    logic              WB_RF_enable;
    logic              WB_align_err;

    // Upstream pipeline drives the EX/MEM fields and observes write-back.
    modport master (
        output in_MEM_load_instr, in_MEM_RF_enable, in_MEM_Size_enable,
               in_MEM_RW_enable, in_MEM_Enable_signal, in_address,
               in_alu_result, in_store_data, in_rd,
        input  WB_data, WB_rd, WB_RF_enable, WB_align_err
    );

    // The memory stage consumes EX/MEM fields and produces write-back.
    modport slave (
        input  in_MEM_load_instr, in_MEM_RF_enable, in_MEM_Size_enable,
               in_MEM_RW_enable, in_MEM_Enable_signal, in_address,
               in_alu_result, in_store_data, in_rd,
        output WB_data, WB_rd, WB_RF_enable, WB_align_err
    );
endinterface

// File: rtl/mem_wb_data_stage_data_ram_core.sv
// Big-endian byte-array data RAM: combinational word/byte read, synchronous byte/word write.
// Latency: read 0 cycles (combinational), write lands at the rising edge.
// Backpressure: none; contents are not reset.
module data_ram_core
    import arm_pipe_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [ADDR_W-1:0] addr3;

    // Byte lanes wrap modulo the RAM depth; aligned words never reach the wrap.
    assign addr1 = addr + ADDR_W'(1);
    assign addr2 = addr + ADDR_W'(2);
    assign addr3 = addr + ADDR_W'(3);

    // Combinational read: MSB lives at the lowest address; byte reads zero-extend.
    always_comb begin
        rdata = 32'h0;
        if (size == SIZE_BYTE) begin
            rdata = {24'h0, mem[addr]};
        end else begin
            rdata = {mem[addr], mem[addr1], mem[addr2], mem[addr3]};
        end
    end

    // Synchronous write; a byte store touches only the addressed location.
    always_ff @(posedge clk) begin
        if (we) begin
            if (size == SIZE_WORD) begin
                mem[addr]  <= wdata[31:24];
                mem[addr1] <= wdata[23:16];
                mem[addr2] <= wdata[15:8];
                mem[addr3] <= wdata[7:0];
            end else begin
                mem[addr]  <= wdata[7:0];
            end
        end
    end

endmodule

// File: rtl/mem_wb_data_stage.sv
// ARM memory stage: data RAM access, misalignment check, WB mux and WB register.
// Latency: one cycle from EX/MEM inputs to WB_* outputs.
// Backpressure: none; accepts one operation every cycle.
module mem_wb_data_stage
    import arm_pipe_pkg::*;
#(
    parameter int ADDR_W = 8,
    // Word width is architectural; the datapath below is built for 32 bits only.
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 R_n,
    mem_wb_data_stage_if.slave   bus
);

    logic              misaligned;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic [DATA_W-1:0] wb_sel_data;
    wb_t               wb_next;
    wb_t               wb_q;

    // Word accesses need A[1:0] = 00; byte accesses are always legal.
    assign misaligned = bus.in_MEM_Enable_signal
                      && (bus.in_MEM_Size_enable == SIZE_WORD)
                      && (bus.in_address[1:0] != 2'b00);

    // Gating with R_n drops a store whose edge arrives while reset is held.
    assign ram_we = bus.in_MEM_Enable_signal
                 && (bus.in_MEM_RW_enable == RW_WRITE)
                 && !misaligned
                 && R_n;

    data_ram_core #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .size  (bus.in_MEM_Size_enable),
        .addr  (bus.in_address),
        .wdata (bus.in_store_data),
        .rdata (ram_rdata)
    );

    // RAM data only for an active load; everything else forwards the EX result.
    assign wb_sel_data = (bus.in_MEM_load_instr && bus.in_MEM_Enable_signal)
                       ? ram_rdata : bus.in_alu_result;

    // Build the next WB bundle; a misaligned access kills data and RF write.
    always_comb begin
        wb_next           = '0;
        wb_next.rd        = bus.in_rd;
        wb_next.data      = misaligned ? '0 : wb_sel_data;
        wb_next.rf_enable = bus.in_MEM_RF_enable && !misaligned;
        wb_next.align_err = misaligned;
    end

    // MEM/WB pipeline register, cleared asynchronously.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_next;
        end
    end

    assign bus.WB_data      = wb_q.data;
    assign bus.WB_rd        = wb_q.rd;
    assign bus.WB_RF_enable = wb_q.rf_enable;
    assign bus.WB_align_err = wb_q.align_err;

endmodule

// File: tb/tb_mem_wb_data_stage.sv
// Self-checking bench for mem_wb_data_stage: vector table plus scoreboard queue.
// Latency: expects WB_* one clock after inputs are presented.
// Backpressure: none exercised; the stage never stalls.
module tb_mem_wb_data_stage;

    typedef struct {
        logic        load;
        logic        rf;
        logic        size;
        logic        rw;
        logic        en;
        logic [7:0]  addr;
        logic [31:0] alu;
        logic [31:0] st;
        logic [3:0]  rd;
        logic [31:0] e_data;
        logic        e_rf;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  rd;
        logic        rf;
        logic        err;
    } exp_t;

    logic clk;
    logic R_n;
    int   tests;
    int   fails;
    exp_t sb[$];
    vec_t tbl[$];

    mem_wb_data_stage_if #(.ADDR_W(8)) bus ();

    mem_wb_data_stage #(
        .ADDR_W (8),
        .DATA_W (32)
    ) dut (
        .clk (clk),
        .R_n (R_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always terminates.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic load, rf, size, rw, en, input logic [7:0] addr,
                                input logic [31:0] alu, st, input logic [3:0] rd,
                                input logic [31:0] e_data, input logic e_rf, e_err);
        vec_t v;
        v.load = load; v.rf = rf; v.size = size; v.rw = rw; v.en = en;
        v.addr = addr; v.alu = alu; v.st = st; v.rd = rd;
        v.e_data = e_data; v.e_rf = e_rf; v.e_err = e_err;
        return v;
    endfunction

    // Store word: WB carries the EX result unless misaligned.
    function automatic vec_t st_w(input logic [7:0] a, input logic [31:0] d, input logic [3:0] rd, input logic err);
        return mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a, {24'h0, a}, d, rd, err ? 32'h0 : {24'h0, a}, 1'b0, err);
    endfunction
    function automatic vec_t st_b(input logic [7:0] a, input logic [31:0] d, input logic [3:0] rd);
        return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a, {24'h0, a}, d, rd, {24'h0, a}, 1'b0, 1'b0);
    endfunction
    function automatic vec_t ld_w(input logic [7:0] a, input logic [31:0] e, input logic [3:0] rd, input logic err);
        return mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, a, 32'h5A5A_0000, 32'hFFFF_FFFF, rd, err ? 32'h0 : e, !err, err);
    endfunction
    function automatic vec_t ld_b(input logic [7:0] a, input logic [31:0] e, input logic [3:0] rd);
        return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, a, 32'h5A5A_0000, 32'hFFFF_FFFF, rd, e, 1'b1, 1'b0);
    endfunction

    task automatic drive(input vec_t v);
        bus.in_MEM_load_instr    = v.load;
        bus.in_MEM_RF_enable     = v.rf;
        bus.in_MEM_Size_enable   = v.size;
        bus.in_MEM_RW_enable     = v.rw;
        bus.in_MEM_Enable_signal = v.en;
        bus.in_address           = v.addr;
        bus.in_alu_result        = v.alu;
        bus.in_store_data        = v.st;
        bus.in_rd                = v.rd;
    endtask

    task automatic check_wb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, got none expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".data"}, bus.WB_data, e.data);
            chk({tag, ".rd"},   {28'h0, bus.WB_rd}, {28'h0, e.rd});
            chk({tag, ".rf"},   {31'h0, bus.WB_RF_enable}, {31'h0, e.rf});
            chk({tag, ".err"},  {31'h0, bus.WB_align_err}, {31'h0, e.err});
        end
    endtask

    // Drive one operation at the falling edge, compare one clock later.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        drive(v);
        e.data = v.e_data; e.rd = v.rd; e.rf = v.e_rf; e.err = v.e_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_wb(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".data"}, bus.WB_data, 32'h0);
        chk({tag, ".rd"},   {28'h0, bus.WB_rd}, 32'h0);
        chk({tag, ".rf"},   {31'h0, bus.WB_RF_enable}, 32'h0);
        chk({tag, ".err"},  {31'h0, bus.WB_align_err}, 32'h0);
    endtask

    initial begin
        vec_t v;
        tests = 0;
        fails = 0;
        R_n   = 1'b0;
        drive(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h55, 32'h0, 4'd5, 32'h55, 1'b1, 1'b0));
        #1;
        chk_zero("reset_init");
        #2;
        R_n = 1'b1;
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h55, 32'h0, 4'd5, 32'h55, 1'b1, 1'b0), "pass55");

        // Async reset mid-cycle with RF enable still requested.
        #1;
        R_n = 1'b0;
        #1;
        chk_zero("reset_async");
        R_n = 1'b1;
        step(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'hAA, 32'h0, 4'd3, 32'hAA, 1'b1, 1'b0), "passAA");

        tbl.push_back(st_w(8'h10, 32'hDEAD_BEEF, 4'd1, 1'b0));
        tbl.push_back(ld_w(8'h10, 32'hDEAD_BEEF, 4'd2, 1'b0));
        tbl.push_back(ld_b(8'h10, 32'h0000_00DE, 4'd3));
        tbl.push_back(ld_b(8'h11, 32'h0000_00AD, 4'd4));
        tbl.push_back(ld_b(8'h12, 32'h0000_00BE, 4'd5));
        tbl.push_back(ld_b(8'h13, 32'h0000_00EF, 4'd6));
        tbl.push_back(st_b(8'h20, 32'h0000_0011, 4'd7));
        tbl.push_back(st_b(8'h22, 32'h0000_0033, 4'd8));
        tbl.push_back(st_b(8'h21, 32'h1234_5677, 4'd9));
        tbl.push_back(ld_b(8'h21, 32'h0000_0077, 4'd10));
        tbl.push_back(ld_b(8'h20, 32'h0000_0011, 4'd11));
        tbl.push_back(ld_b(8'h22, 32'h0000_0033, 4'd12));
        tbl.push_back(st_w(8'h12, 32'h0102_0304, 4'd13, 1'b1));
        tbl.push_back(ld_w(8'h10, 32'hDEAD_BEEF, 4'd14, 1'b0));
        tbl.push_back(ld_w(8'h13, 32'h0, 4'd15, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h99, 32'h0, 4'd7, 32'h99, 1'b1, 1'b0));
        tbl.push_back(st_w(8'hFC, 32'h0102_0304, 4'd1, 1'b0));
        tbl.push_back(ld_w(8'hFC, 32'h0102_0304, 4'd2, 1'b0));
        tbl.push_back(ld_b(8'hFF, 32'h0000_0004, 4'd3));
        tbl.push_back(ld_b(8'hFC, 32'h0000_0001, 4'd4));
        tbl.push_back(st_w(8'h30, 32'hCAFE_F00D, 4'd5, 1'b0));

        foreach (tbl[i]) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset asserted before the store edge: the store must be lost.
        @(negedge clk);
        drive(st_w(8'h30, 32'h1111_1111, 4'd6, 1'b0));
        R_n = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("reset_store");
        R_n = 1'b1;
        step(ld_w(8'h30, 32'hCAFE_F00D, 4'd9, 1'b0), "after_rst_ld");
        step(ld_b(8'h33, 32'h0000_000D, 4'd10), "after_rst_ldb");

        v = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0);
        step(v, "idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
